// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: access-size encoding and
// byte-lane mask generation for 32-bit memory accesses.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        SIZE_B    = 2'd0,
        SIZE_H    = 2'd1,
        SIZE_W    = 2'd2,
        SIZE_RSVD = 2'd3
    } mem_size_t;

    // Byte lanes touched by an aligned access; reserved size behaves as a word.
    function automatic logic [3:0] byte_mask(input logic [1:0] a, input logic [1:0] size);
        logic [3:0] m;
        case (mem_size_t'(size))
            SIZE_B:  m = 4'b0001 << a;
            SIZE_H:  m = 4'b0011 << {a[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Per-entry comparator: does a buffered store overlap the load under check,
// and does it supply every byte the load needs.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              ent_valid,
    input  logic [ADDR_W-1:0] ent_addr,
    input  logic [1:0]        ent_size,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    output logic              overlap,
    output logic              covers
);

    logic [3:0] ent_mask;
    logic [3:0] ld_mask;
    logic       same_word;

    assign ent_mask  = byte_mask(ent_addr[1:0], ent_size);
    assign ld_mask   = byte_mask(ld_addr[1:0], ld_size);
    assign same_word = (ent_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    assign overlap   = ent_valid && same_word && (|(ent_mask & ld_mask));
    assign covers    = ((ent_mask & ld_mask) == ld_mask);

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between commit and the data-bus write port.
// Drains committed stores FIFO-style, flags loads that overlap buffered
// stores, and reports when it is fully drained for FENCE.
// Optional macro STORE_BUFFER_FWD_EN adds store-to-load forwarding from the
// youngest overlapping entry.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_val,
    input  logic [1:0]               in_size,
    input  logic                     in_valid,
    output logic                     full,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [1:0]               wr_size,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [1:0]               ld_size,
    input  logic                     ld_check,
    output logic                     ld_hazard,
    input  logic                     fence_req,
    output logic                     drained,
    output logic [$clog2(DEPTH):0]   count
`ifdef STORE_BUFFER_FWD_EN
    ,
    output logic                     ld_fwd_valid,
    output logic [DATA_W-1:0]        ld_fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [1:0]        size_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  overlap_vec;
    logic [DEPTH-1:0]  covers_vec;

    // fence_req needs no action here: pushes are never blocked and drained
    // already tells execute when it may proceed.
    logic unused_fence;
    assign unused_fence = fence_req;

    // Reset suppresses both the push and the presented head so nothing
    // escapes while the buffer is being discarded.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign push     = in_valid && !full && !reset;
    assign wr_valid = (count_q != '0) && !reset;
    assign pop      = wr_valid && wr_ready;
    assign wr_addr  = wr_valid ? addr_q[rd_ptr_q] : '0;
    assign wr_data  = wr_valid ? data_q[rd_ptr_q] : '0;
    assign wr_size  = wr_valid ? size_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign drained  = (count_q == '0) && !push;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state: pointers, count and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) valid_q[wr_ptr_q] <= 1'b1;
            if (pop)  valid_q[rd_ptr_q] <= 1'b0;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_val;
            size_q[wr_ptr_q] <= in_size;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        store_buffer_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .ent_valid (valid_q[g]),
            .ent_addr  (addr_q[g]),
            .ent_size  (size_q[g]),
            .ld_addr   (ld_addr),
            .ld_size   (ld_size),
            .overlap   (overlap_vec[g]),
            .covers    (covers_vec[g])
        );
    end

`ifdef STORE_BUFFER_FWD_EN
    // Right-justify the bytes the load reads out of a lane-aligned word.
    function automatic logic [DATA_W-1:0] fwd_extract(input logic [DATA_W-1:0] lanes,
                                                      input logic [1:0] ofs,
                                                      input logic [1:0] size);
        logic [DATA_W-1:0] shifted;
        shifted = lanes >> {ofs, 3'b000};
        case (mem_size_t'(size))
            SIZE_B:  return shifted & DATA_W'(32'h0000_00FF);
            SIZE_H:  return shifted & DATA_W'(32'h0000_FFFF);
            default: return shifted;
        endcase
    endfunction

    logic             sel_found;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [DATA_W-1:0] lane_data;

    // Youngest-first select: walk back from the most recent push.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = wr_ptr_q - PTR_W'(i + 1);
            if (!sel_found && overlap_vec[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // Forward when the youngest overlapping store supplies every load byte.
    always_comb begin
        ld_hazard    = 1'b0;
        ld_fwd_valid = 1'b0;
        ld_fwd_data  = '0;
        lane_data    = data_q[sel_idx] << {addr_q[sel_idx][1:0], 3'b000};
        if (ld_check && !reset && sel_found) begin
            if (covers_vec[sel_idx] && (size_q[sel_idx] != SIZE_RSVD)) begin
                ld_fwd_valid = 1'b1;
                ld_fwd_data  = fwd_extract(lane_data, ld_addr[1:0], ld_size);
            end else begin
                ld_hazard = 1'b1;
            end
        end
    end
`else
    logic unused_covers;
    assign unused_covers = ^covers_vec;
    assign ld_hazard     = ld_check && !reset && (|overlap_vec);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed corner sequences, a vector
// table of load checks, and randomized traffic against a queue model.
// Builds with or without STORE_BUFFER_FWD_EN.
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_val;
    logic [1:0]        in_size;
    logic              in_valid;
    logic              full;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        wr_size;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic              ld_check;
    logic              ld_hazard;
    logic              fence_req;
    logic              drained;
    logic [2:0]        count;
`ifdef STORE_BUFFER_FWD_EN
    logic              ld_fwd_valid;
    logic [DATA_W-1:0] ld_fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_addr   (in_addr),
        .in_val    (in_val),
        .in_size   (in_size),
        .in_valid  (in_valid),
        .full      (full),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_size   (wr_size),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .ld_addr   (ld_addr),
        .ld_size   (ld_size),
        .ld_check  (ld_check),
        .ld_hazard (ld_hazard),
        .fence_req (fence_req),
        .drained   (drained),
        .count     (count)
`ifdef STORE_BUFFER_FWD_EN
        ,
        .ld_fwd_valid (ld_fwd_valid),
        .ld_fwd_data  (ld_fwd_data)
`endif
    );

    // Accesses must be naturally aligned.
    function automatic bit aligned(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd1) return (a[0] == 1'b0);
        if (s >= 2'd2) return (a[1:0] == 2'b00);
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (in_valid) assert (aligned(in_addr, in_size)) else $error("misaligned store");
        if (ld_check) assert (aligned(ld_addr, ld_size)) else $error("misaligned load");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_addr = 0; in_val = 0; in_size = 0;
        wr_ready = 0; ld_check = 0; ld_addr = 0; ld_size = 0; fence_req = 0;
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        in_valid = 1; in_addr = a; in_val = d; in_size = s;
        tick();
        in_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle();
        tick(); tick();
        reset = 0;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } ent_t;
    ent_t mq[$];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // Load check over byte address ranges; youngest overlapping store decides.
    task automatic model_load(input logic chk, input logic [31:0] la, input logic [1:0] ls,
                              output logic haz, output logic fv, output logic [31:0] fd);
        longint lo, lb, so, sb;
        int idx;
        haz = 0; fv = 0; fd = 0; idx = -1;
        if (!chk) return;
        lo = longint'(la); lb = nbytes(ls);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            so = longint'(mq[i].addr); sb = nbytes(mq[i].size);
            if (idx < 0 && lo < so + sb && so < lo + lb) idx = i;
        end
        if (idx < 0) return;
`ifdef STORE_BUFFER_FWD_EN
        so = longint'(mq[idx].addr); sb = nbytes(mq[idx].size);
        if (mq[idx].size != 2'd3 && lo >= so && lo + lb <= so + sb) begin
            logic [63:0] sh;
            sh = 64'(mq[idx].data) >> (8 * (lo - so));
            fv = 1;
            fd = (lb == 4) ? sh[31:0] : sh[31:0] & ((32'd1 << (8 * lb)) - 32'd1);
        end else begin
            haz = 1;
        end
`else
        haz = 1;
`endif
    endtask

    typedef struct {
        logic        chk;
        logic [31:0] la;
        logic [1:0]  ls;
        logic        haz_nf;
        logic        haz_f;
        logic        fv;
        logic [31:0] fd;
    } hv_t;
    hv_t tbl[7];

    initial begin
        logic        mh, mf;
        logic [31:0] md;
        int          cyc;

        tbl[0] = '{1'b1, 32'h200, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h204, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h200, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 32'h203, 2'd0, 1'b1, 1'b0, 1'b1, 32'hAB};
        tbl[4] = '{1'b1, 32'h202, 2'd1, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 32'h200, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 32'h201, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0};

        // ---- 1: reset with in_valid held high ----
        reset = 1; idle(); in_valid = 1; in_addr = 32'h40; in_size = 2;
        tick(); tick();
        check("rst_full", full, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_drained", drained, 1);
        check("rst_count", count, 0);
        check("rst_wr_addr", wr_addr, 0);
        reset = 0; in_valid = 0;
        settle();
        check("post_rst_full", full, 0);
        check("post_rst_wr_valid", wr_valid, 0);
        check("post_rst_drained", drained, 1);
        check("post_rst_count", count, 0);
        tick();

        // ---- 2: fill, drop fifth push, drain in order ----
        for (int k = 0; k < 4; k++) push1(32'h100 + 32'(4 * k), 32'hA000 + 32'(k), 2'd2);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        push1(32'h110, 32'hDEAD, 2'd2);
        check("drop5_count", count, 4);
        wr_ready = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("drain_valid", wr_valid, 1);
            check("drain_addr", wr_addr, 32'h100 + 32'(4 * k));
            check("drain_data", wr_data, 32'hA000 + 32'(k));
            tick();
        end
        wr_ready = 0;
        check("drain_empty_count", count, 0);
        check("drain_empty_valid", wr_valid, 0);

        // ---- 3: full with push and pop together ----
        for (int k = 0; k < 4; k++) push1(32'h500 + 32'(4 * k), 32'(k), 2'd2);
        in_valid = 1; in_addr = 32'h5F0; in_size = 2; wr_ready = 1;
        settle();
        check("fpp_head", wr_addr, 32'h500);
        tick();
        check("fpp_count", count, 3);
        in_addr = 32'h600; wr_ready = 0;
        tick();
        in_valid = 0;
        check("fpp_refill_count", count, 4);
        wr_ready = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("fpp_order", wr_addr, (k < 3) ? 32'h504 + 32'(4 * k) : 32'h600);
            tick();
        end
        wr_ready = 0;
        check("fpp_empty", count, 0);

        // ---- 4: load-check vector table against a buffered byte store ----
        push1(32'h203, 32'hAB, 2'd0);
        for (int i = 0; i < 7; i++) begin
            ld_check = tbl[i].chk; ld_addr = tbl[i].la; ld_size = tbl[i].ls;
            settle();
`ifdef STORE_BUFFER_FWD_EN
            check($sformatf("tbl%0d_hazard", i), ld_hazard, tbl[i].haz_f);
            check($sformatf("tbl%0d_fwd_valid", i), ld_fwd_valid, tbl[i].fv);
            check($sformatf("tbl%0d_fwd_data", i), ld_fwd_data, tbl[i].fd);
`else
            check($sformatf("tbl%0d_hazard", i), ld_hazard, tbl[i].haz_nf);
`endif
        end
        ld_check = 0;
        wr_ready = 1; tick(); wr_ready = 0;

        // ---- 5: youngest entry and partial cover ----
        push1(32'h300, 32'h11223344, 2'd2);
        push1(32'h300, 32'h55667788, 2'd2);
        ld_check = 1; ld_addr = 32'h301; ld_size = 2'd0;
        settle();
`ifdef STORE_BUFFER_FWD_EN
        check("fwd_lbu_valid", ld_fwd_valid, 1);
        check("fwd_lbu_data", ld_fwd_data, 32'h77);
        check("fwd_lbu_hazard", ld_hazard, 0);
`else
        check("nofwd_lbu_hazard", ld_hazard, 1);
`endif
        ld_check = 0;
        push1(32'h302, 32'h9999, 2'd1);
        ld_check = 1; ld_addr = 32'h300; ld_size = 2'd2;
        settle();
        check("partial_hazard", ld_hazard, 1);
`ifdef STORE_BUFFER_FWD_EN
        check("partial_fwd_valid", ld_fwd_valid, 0);
`endif
        ld_check = 0;
        wr_ready = 1; tick(); tick(); tick(); wr_ready = 0;
        check("t5_empty", count, 0);

        // ---- 6: fence drain with toggling wr_ready ----
        fence_req = 1;
        push1(32'h700, 32'h1, 2'd2);
        push1(32'h704, 32'h2, 2'd2);
        for (int k = 0; k < 4; k++) begin
            wr_ready = (k % 2 == 1);
            settle();
            check("fence_busy", drained, 0);
            tick();
        end
        wr_ready = 0;
        settle();
        check("fence_done", drained, 1);
        in_valid = 1; in_addr = 32'h708; in_size = 2;
        settle();
        check("fence_push_now", drained, 0);
        tick();
        in_addr = 32'h70C; wr_ready = 1;
        settle();
        check("fence_last_push", drained, 0);
        tick();
        in_valid = 0;
        check("fence_after_push", drained, 0);
        check("fence_after_count", count, 1);
        tick();
        wr_ready = 0;
        check("fence_final", drained, 1);
        fence_req = 0;

        // ---- reset while a head is presented ----
        push1(32'h800, 32'h5, 2'd2);
        push1(32'h804, 32'h6, 2'd2);
        reset = 1; wr_ready = 1;
        settle();
        check("midrst_wr_valid", wr_valid, 0);
        tick();
        reset = 0; wr_ready = 0;
        check("midrst_count", count, 0);
        check("midrst_drained", drained, 1);

        // ---- randomized traffic against the queue model ----
        mq.delete();
        for (cyc = 0; cyc < 400; cyc++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 99) < 55);
            in_size  = s;
            in_addr  = 32'h400 + 32'($urandom_range(0, 3) * 4);
            if (s == 2'd0) in_addr[1:0] = 2'($urandom_range(0, 3));
            if (s == 2'd1) in_addr[1]   = 1'($urandom_range(0, 1));
            in_val   = $urandom;
            wr_ready = ($urandom_range(0, 99) < 45);
            fence_req = 1'($urandom_range(0, 1));
            ld_check = 1'($urandom_range(0, 1));
            ld_size  = 2'($urandom_range(0, 2));
            ld_addr  = 32'h400 + 32'($urandom_range(0, 3) * 4);
            if (ld_size == 2'd0) ld_addr[1:0] = 2'($urandom_range(0, 3));
            if (ld_size == 2'd1) ld_addr[1]   = 1'($urandom_range(0, 1));
            settle();
            check("rnd_count", count, 64'(mq.size()));
            check("rnd_full", full, 64'(mq.size() == DEPTH));
            check("rnd_wr_valid", wr_valid, 64'(mq.size() != 0));
            check("rnd_wr_addr", wr_addr, (mq.size() != 0) ? 64'(mq[0].addr) : 64'h0);
            check("rnd_wr_data", wr_data, (mq.size() != 0) ? 64'(mq[0].data) : 64'h0);
            check("rnd_wr_size", wr_size, (mq.size() != 0) ? 64'(mq[0].size) : 64'h0);
            check("rnd_drained", drained, 64'(mq.size() == 0 && !in_valid));
            model_load(ld_check, ld_addr, ld_size, mh, mf, md);
            check("rnd_hazard", ld_hazard, 64'(mh));
`ifdef STORE_BUFFER_FWD_EN
            check("rnd_fwd_valid", ld_fwd_valid, 64'(mf));
            check("rnd_fwd_data", ld_fwd_data, 64'(md));
`endif
            begin
                bit do_push, do_pop;
                do_push = in_valid && (mq.size() < DEPTH);
                do_pop  = (mq.size() != 0) && wr_ready;
                tick();
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back('{in_addr, in_val, in_size});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
